// File: rtl/eth_tx_framer.sv
// eth_tx_framer: GMII transmit framer. Wraps each MAC frame with a 7x0x55 + 0xD5
// preamble, zero-pads short frames to MIN_LEN, flags oversize bytes on gmii_txer,
// and enforces an inter-frame gap.
// Optional feature: define ETH_TX_FCS_EN to append the 4-byte CRC-32 FCS. With the
// macro undefined the frame ends on its last data/pad byte and no CRC logic exists.
module eth_tx_framer #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txd,
    input  logic       txen,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
    // Eight staged bytes plus the output register give the nine-cycle txd->line latency,
    // which exactly covers the eight preamble/SFD cycles.
    localparam int DLY = 8;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

`ifdef ETH_TX_FCS_EN
    localparam state_t POST_PAYLOAD = S_FCS;
    localparam logic   PAYLOAD_DONE = 1'b0;
`else
    localparam state_t POST_PAYLOAD = S_IFG;
    localparam logic   PAYLOAD_DONE = 1'b1;
`endif

    state_t          state_q, state_d;
    logic [7:0]      dl_q [DLY];
    logic [DLY-2:0]  dv_q;          // valid flags; only needed up to the look-ahead stage
    logic            txen_q;
    logic            in_active_q, in_active_d;
    logic [10:0]     cnt_q, cnt_d, cnt_inc;
    logic [15:0]     sub_q, sub_d;  // preamble / FCS / IFG phase counter
    logic [7:0]      txd_q, txd_d;
    logic            gtxen_q, txen_d;
    logic            txer_q, txer_d;
    logic            done_q, done_d;
    logic            busy_q, ovr_q;
    logic            rise, accept, tail_pad;

    assign rise     = txen & ~txen_q;
    assign accept   = rise && (state_q == S_IDLE);
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign tail_pad = (int'(cnt_q) + 1) < MIN_LEN;

    // Input capture stays open from an accepted rise until the first txen=0.
    assign in_active_d = accept | (in_active_q & txen);

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d, fcs_w;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs_w = ~crc_q;

    // CRC accumulates every byte leaving the line in DATA and PAD.
    always_comb begin
        crc_d = crc_q;
        if (accept) begin
            crc_d = 32'hFFFFFFFF;
        end else if (state_q == S_DATA) begin
            crc_d = crc_step(crc_q, dl_q[DLY-1]);
        end else if (state_q == S_PAD) begin
            crc_d = crc_step(crc_q, 8'h00);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    // Next state and next registered line outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        txd_d   = 8'h00;
        txen_d  = 1'b0;
        txer_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    sub_d   = 16'd1;
                    cnt_d   = '0;
                    txd_d   = 8'h55;
                    txen_d  = 1'b1;
                end
            end
            S_PRE: begin
                txen_d = 1'b1;
                if (sub_q == 16'd7) begin
                    txd_d   = 8'hD5;
                    state_d = S_DATA;
                end else begin
                    txd_d = 8'h55;
                    sub_d = sub_q + 16'd1;
                end
            end
            S_DATA: begin
                txen_d = 1'b1;
                txd_d  = dl_q[DLY-1];
                txer_d = int'(cnt_q) >= MAX_LEN;
                cnt_d  = cnt_inc;
                // Look one stage ahead so the line never drops txen between payload and tail.
                if (!dv_q[DLY-2]) begin
                    if (tail_pad) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = POST_PAYLOAD;
                        sub_d   = '0;
                        done_d  = PAYLOAD_DONE;
                    end
                end
            end
            S_PAD: begin
                txen_d = 1'b1;
                cnt_d  = cnt_inc;
                if (!tail_pad) begin
                    state_d = POST_PAYLOAD;
                    sub_d   = '0;
                    done_d  = PAYLOAD_DONE;
                end
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                txen_d = 1'b1;
                txd_d  = fcs_w[{sub_q[1:0], 3'b000} +: 8];
                txer_d = int'(cnt_q) > MAX_LEN;
                if (sub_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    state_d = S_IFG;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + 16'd1;
                end
            end
`endif
            S_IFG: begin
                if (int'(sub_q) >= IFG_CYCLES - 1) begin
                    state_d = S_IDLE;
                end else begin
                    sub_d = sub_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, delay line and registered outputs.
    always_ff @(posedge clk) begin
        // Tracked through reset so a txen level held across reset is not seen as a rise.
        txen_q <= txen;
        if (reset) begin
            state_q     <= S_IDLE;
            in_active_q <= 1'b0;
            cnt_q       <= '0;
            sub_q       <= '0;
            dv_q        <= '0;
            for (int i = 0; i < DLY; i++) begin
                dl_q[i] <= 8'h00;
            end
            txd_q   <= 8'h00;
            gtxen_q <= 1'b0;
            txer_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_active_q <= in_active_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            dv_q        <= {dv_q[DLY-3:0], in_active_d};
            dl_q[0]     <= txd;
            for (int i = 1; i < DLY; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            txd_q   <= txd_d;
            gtxen_q <= txen_d;
            txer_q  <= txer_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
            ovr_q   <= rise && (state_q != S_IDLE);
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_txen  = gtxen_q;
    assign gmii_txer  = txer_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
endmodule
